// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the shared-memory MIPS datapath.
// Memory handshake: a strobe (MemRead/MemWrite) is held while MemReady is low; the access completes on the cycle with MemReady high.
interface multicycle_control_if #(
    parameter int COUNT_WIDTH = 32,
    parameter int STATE_WIDTH = 4
);
    logic [5:0]             OP;
    logic [5:0]             Funct;
    logic                   Zero;
    logic                   MemReady;
    logic                   PCWrite;
    logic                   IorD;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   IRWrite;
    logic [1:0]             RegDst;
    logic [1:0]             MemtoReg;
    logic                   RegWrite;
    logic                   ALUSrcA;
    logic [1:0]             ALUSrcB;
    logic [2:0]             ALUOp;
    logic [1:0]             PCSource;
    logic                   InstrDone;
    logic [STATE_WIDTH-1:0] State;
    logic [COUNT_WIDTH-1:0] RetiredCount;

    modport master (
        output OP, Funct, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, State, RetiredCount
    );

    modport slave (
        input  OP, Funct, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, State, RetiredCount
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: steps each instruction through fetch/decode/execute/memory/write-back
// and counts retired instructions.
module multicycle_control #(
    parameter int COUNT_WIDTH = 32,
    parameter int STATE_WIDTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B, FN_JR  = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE  = 4'd6, S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXE   = 4'd10, S_IWB  = 4'd11,
        S_JR     = 4'd12
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [COUNT_WIDTH-1:0] retired_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (bus.InstrDone) retired_count <= retired_count + 1'b1;
        end
    end

    // Reset forces every strobe and select low, so no write escapes during the reset cycle.
    always_comb begin
        next_state    = S_FETCH;
        bus.PCWrite   = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 2'b00;
        bus.MemtoReg  = 2'b00;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 3'b000;
        bus.PCSource  = 2'b00;
        bus.InstrDone = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    if (bus.MemReady) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        next_state  = S_DECODE;
                    end else begin
                        next_state  = S_FETCH;
                    end
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    case (bus.OP)
                        OP_LW, OP_SW:                     next_state = S_MEMADR;
                        OP_RTYPE:                         next_state = (bus.Funct == FN_JR) ? S_JR : S_RTEXE;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = S_IEXE;
                        OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
                        OP_J, OP_JAL:                     next_state = S_JUMP;
                        default:                          bus.InstrDone = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    next_state  = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    next_state  = bus.MemReady ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    bus.RegWrite  = 1'b1;
                    bus.MemtoReg  = 2'b01;
                    bus.InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite  = 1'b1;
                    bus.IorD      = 1'b1;
                    bus.InstrDone = bus.MemReady;
                    next_state    = bus.MemReady ? S_FETCH : S_MEMWR;
                end
                S_RTEXE: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 3'b111;
                    next_state  = S_ALUWB;
                end
                S_ALUWB: begin
                    bus.RegWrite  = 1'b1;
                    bus.RegDst    = 2'b01;
                    bus.InstrDone = 1'b1;
                end
                S_IEXE: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    case (bus.OP)
                        OP_ANDI: bus.ALUOp = 3'b011;
                        OP_ORI:  bus.ALUOp = 3'b010;
                        OP_LUI:  bus.ALUOp = 3'b100;
                        default: bus.ALUOp = 3'b000;
                    endcase
                    next_state = S_IWB;
                end
                S_IWB: begin
                    bus.RegWrite  = 1'b1;
                    bus.InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA   = 1'b1;
                    bus.ALUOp     = 3'b001;
                    bus.PCSource  = 2'b01;
                    bus.PCWrite   = ((bus.OP == OP_BEQ) && bus.Zero) || ((bus.OP == OP_BNE) && !bus.Zero);
                    bus.InstrDone = 1'b1;
                end
                S_JUMP: begin
                    bus.PCWrite   = 1'b1;
                    bus.PCSource  = 2'b10;
                    bus.InstrDone = 1'b1;
                    // PC already holds PC+4 here, which is the JAL link value.
                    if (bus.OP == OP_JAL) begin
                        bus.RegWrite = 1'b1;
                        bus.RegDst   = 2'b10;
                        bus.MemtoReg = 2'b10;
                    end
                end
                S_JR: begin
                    bus.PCWrite   = 1'b1;
                    bus.PCSource  = 2'b11;
                    bus.InstrDone = 1'b1;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign bus.State        = STATE_WIDTH'(state);
    assign bus.RetiredCount = retired_count;
endmodule
